// File: rtl/mips_instr_encoder_pkg.sv
// Shared MIPS ISA constants, mnemonic indices and encoder FSM states.
// Opcode/funct values match those decoded by the single-cycle control unit.
package mips_instr_encoder_pkg;

    typedef enum logic [4:0] {
        OPSEL_ADD   = 5'd0,
        OPSEL_ADDU  = 5'd1,
        OPSEL_AND   = 5'd2,
        OPSEL_JR    = 5'd3,
        OPSEL_NOR   = 5'd4,
        OPSEL_OR    = 5'd5,
        OPSEL_SLT   = 5'd6,
        OPSEL_SLTU  = 5'd7,
        OPSEL_SUB   = 5'd8,
        OPSEL_SUBU  = 5'd9,
        OPSEL_SLL   = 5'd10,
        OPSEL_SRL   = 5'd11,
        OPSEL_SRA   = 5'd12,
        OPSEL_ADDI  = 5'd13,
        OPSEL_ADDIU = 5'd14,
        OPSEL_ANDI  = 5'd15,
        OPSEL_BEQ   = 5'd16,
        OPSEL_BNE   = 5'd17,
        OPSEL_LBU   = 5'd18,
        OPSEL_LHU   = 5'd19,
        OPSEL_LUI   = 5'd20,
        OPSEL_LW    = 5'd21,
        OPSEL_ORI   = 5'd22,
        OPSEL_SLTI  = 5'd23,
        OPSEL_SLTIU = 5'd24,
        OPSEL_SB    = 5'd25,
        OPSEL_SH    = 5'd26,
        OPSEL_SW    = 5'd27,
        OPSEL_J     = 5'd28,
        OPSEL_JAL   = 5'd29
    } op_sel_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/mips_instr_encoder_pack.sv
// Combinational mnemonic-to-word packer; flags op_sel codes with no mnemonic.
// Fields an instruction does not use are forced to zero regardless of the request.
module mips_instr_pack
    import mips_instr_encoder_pkg::*;
(
    input  logic [4:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_sel_e'(op_sel))
            OPSEL_ADD:   word = r_word(rs, rt, rd, 5'd0, FUNCT_ADD);
            OPSEL_ADDU:  word = r_word(rs, rt, rd, 5'd0, FUNCT_ADDU);
            OPSEL_AND:   word = r_word(rs, rt, rd, 5'd0, FUNCT_AND);
            OPSEL_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FUNCT_JR);
            OPSEL_NOR:   word = r_word(rs, rt, rd, 5'd0, FUNCT_NOR);
            OPSEL_OR:    word = r_word(rs, rt, rd, 5'd0, FUNCT_OR);
            OPSEL_SLT:   word = r_word(rs, rt, rd, 5'd0, FUNCT_SLT);
            OPSEL_SLTU:  word = r_word(rs, rt, rd, 5'd0, FUNCT_SLTU);
            OPSEL_SUB:   word = r_word(rs, rt, rd, 5'd0, FUNCT_SUB);
            OPSEL_SUBU:  word = r_word(rs, rt, rd, 5'd0, FUNCT_SUBU);
            OPSEL_SLL:   word = r_word(5'd0, rt, rd, shamt, FUNCT_SLL);
            OPSEL_SRL:   word = r_word(5'd0, rt, rd, shamt, FUNCT_SRL);
            OPSEL_SRA:   word = r_word(5'd0, rt, rd, shamt, FUNCT_SRA);
            OPSEL_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
            OPSEL_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
            OPSEL_ANDI:  word = i_word(OP_ANDI, rs, rt, imm);
            OPSEL_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
            OPSEL_BNE:   word = i_word(OP_BNE, rs, rt, imm);
            OPSEL_LBU:   word = i_word(OP_LBU, rs, rt, imm);
            OPSEL_LHU:   word = i_word(OP_LHU, rs, rt, imm);
            OPSEL_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm);
            OPSEL_LW:    word = i_word(OP_LW, rs, rt, imm);
            OPSEL_ORI:   word = i_word(OP_ORI, rs, rt, imm);
            OPSEL_SLTI:  word = i_word(OP_SLTI, rs, rt, imm);
            OPSEL_SLTIU: word = i_word(OP_SLTIU, rs, rt, imm);
            OPSEL_SB:    word = i_word(OP_SB, rs, rt, imm);
            OPSEL_SH:    word = i_word(OP_SH, rs, rt, imm);
            OPSEL_SW:    word = i_word(OP_SW, rs, rt, imm);
            OPSEL_J:     word = j_word(OP_J, target);
            OPSEL_JAL:   word = j_word(OP_JAL, target);
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts mnemonic requests over valid/ready, encodes them and
// writes one word every two cycles into instruction memory from a latched base address.
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    enc_state_e        state;
    enc_state_e        next_state;
    logic [ADDR_W-1:0] ptr;
    logic              last_q;
    logic [31:0]       packed_word;
    logic              illegal;
    logic              accept;
    logic              in_ready_nxt;
    logic              imem_we_nxt;
    logic              done_nxt;

    mips_instr_pack u_pack (
        .op_sel  (op_sel),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm),
        .target  (target),
        .word    (packed_word),
        .illegal (illegal)
    );

    assign accept = (state == ST_RUN) && in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_RUN;
            ST_RUN:   if (accept && !illegal) next_state = ST_WRITE;
            ST_WRITE: next_state = (last_q || ptr == LAST_ADDR) ? ST_DONE : ST_RUN;
            ST_DONE:  if (start) next_state = ST_RUN;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Handshake/strobe outputs are decoded from the upcoming state so they are registered
    // alongside it and line up exactly with the state they describe.
    always_comb begin
        in_ready_nxt = (next_state == ST_RUN);
        imem_we_nxt  = (next_state == ST_WRITE);
        done_nxt     = (next_state == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready <= 1'b0;
            imem_we  <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= in_ready_nxt;
            imem_we  <= imem_we_nxt;
            done     <= done_nxt;
        end
    end

    // Pointer saturates at the last word instead of wrapping; a base past the end is clamped.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            count      <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        ptr   <= (base_addr > LAST_ADDR) ? LAST_ADDR : base_addr;
                        count <= '0;
                        full  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            imem_addr  <= ptr;
                            imem_wdata <= packed_word;
                            last_q     <= in_last;
                        end
                    end
                end
                ST_WRITE: begin
                    count <= count + (ADDR_W + 1)'(1);
                    if (ptr != LAST_ADDR) begin
                        ptr <= ptr + ADDR_W'(1);
                    end else if (!last_q) begin
                        full <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder with a 4-word memory so full/no-wrap
// behaviour is reachable in a handful of requests.
module tb_mips_instr_encoder;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [4:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              done;
    logic              full;
    logic              err;
    logic [ADDR_W:0]   count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   slot;

    mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .op_sel     (op_sel),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .imm        (imm),
        .target     (target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .done       (done),
        .full       (full),
        .err        (err),
        .count      (count)
    );

    always #5 clock = ~clock;

    // Reference encoder written straight from the MIPS opcode/funct tables.
    function automatic logic [31:0] mdl_word(input logic [4:0] op, input logic [4:0] s,
                                             input logic [4:0] t, input logic [4:0] d,
                                             input logic [4:0] sh, input logic [15:0] im,
                                             input logic [25:0] tg);
        logic [31:0] w;
        w = 32'h0;
        case (op)
            5'd0:  w = {6'h00, s, t, d, 5'd0, 6'h20};
            5'd1:  w = {6'h00, s, t, d, 5'd0, 6'h21};
            5'd2:  w = {6'h00, s, t, d, 5'd0, 6'h24};
            5'd3:  w = {6'h00, s, 15'd0, 6'h08};
            5'd4:  w = {6'h00, s, t, d, 5'd0, 6'h27};
            5'd5:  w = {6'h00, s, t, d, 5'd0, 6'h25};
            5'd6:  w = {6'h00, s, t, d, 5'd0, 6'h2A};
            5'd7:  w = {6'h00, s, t, d, 5'd0, 6'h2B};
            5'd8:  w = {6'h00, s, t, d, 5'd0, 6'h22};
            5'd9:  w = {6'h00, s, t, d, 5'd0, 6'h23};
            5'd10: w = {11'd0, t, d, sh, 6'h00};
            5'd11: w = {11'd0, t, d, sh, 6'h02};
            5'd12: w = {11'd0, t, d, sh, 6'h03};
            5'd13: w = {6'h08, s, t, im};
            5'd14: w = {6'h09, s, t, im};
            5'd15: w = {6'h0C, s, t, im};
            5'd16: w = {6'h04, s, t, im};
            5'd17: w = {6'h05, s, t, im};
            5'd18: w = {6'h24, s, t, im};
            5'd19: w = {6'h25, s, t, im};
            5'd20: w = {6'h0F, 5'd0, t, im};
            5'd21: w = {6'h23, s, t, im};
            5'd22: w = {6'h0D, s, t, im};
            5'd23: w = {6'h0A, s, t, im};
            5'd24: w = {6'h0B, s, t, im};
            5'd25: w = {6'h28, s, t, im};
            5'd26: w = {6'h29, s, t, im};
            5'd27: w = {6'h2B, s, t, im};
            5'd28: w = {6'h02, tg};
            5'd29: w = {6'h03, tg};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected word.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_we", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                checkOutput("wr_data", imem_wdata, mon_e.data);
            end
        end
    end

    task automatic start_load(input logic [ADDR_W-1:0] base);
        @(negedge clock);
        start     = 1'b1;
        base_addr = base;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Presents one request once in_ready is seen; queues the expected write if the op is legal.
    task automatic applyStimulus(input logic [4:0] op, input logic [4:0] s, input logic [4:0] t,
                                 input logic [4:0] d, input logic [4:0] sh,
                                 input logic [15:0] im, input logic [25:0] tg,
                                 input logic last, input logic [ADDR_W-1:0] exp_addr,
                                 input logic [31:0] exp_word);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clock);
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        op_sel   = op;
        rs       = s;
        rt       = t;
        rd       = d;
        shamt    = sh;
        imm      = im;
        target   = tg;
        in_last  = last;
        in_valid = 1'b1;
        if (op < 5'd30) begin
            e.addr = exp_addr;
            e.data = exp_word;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clock);
        if (op < 5'd30) begin
            checkOutput("we_latency", 32'(imem_we), 32'd1);
        end else begin
            checkOutput("illegal_err", 32'(err), 32'd1);
            checkOutput("illegal_no_we", 32'(imem_we), 32'd0);
            checkOutput("illegal_ready", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_we"}, 32'(imem_we), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_full"}, 32'(full), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_addr"}, 32'(imem_addr), 32'd0);
        checkOutput({tag, "_wdata"}, imem_wdata, 32'd0);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [4:0]  r_s, r_t, r_d, r_sh;
        logic [15:0] r_im;
        logic [25:0] r_tg;

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        op_sel    = '0;
        rs        = '0;
        rt        = '0;
        rd        = '0;
        shamt     = '0;
        imm       = '0;
        target    = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("reset");

        $display("[TB] program A: R-type, shift, illegal op with in_last");
        start_load(6'd0);
        applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 6'd0, 32'h00221820);
        applyStimulus(5'd10, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0, 6'd1, 32'h00011100);
        applyStimulus(5'd30, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b1, 6'd0, 32'h0);
        @(negedge clock);
        checkOutput("illegal_count", 32'(count), 32'd2);
        checkOutput("illegal_not_done", 32'(done), 32'd0);
        applyStimulus(5'd21, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0, 6'd2, 32'h8FA80004);
        applyStimulus(5'd3, 5'd5, 5'd6, 5'd7, 5'd3, 16'h0, 26'h0, 1'b1, 6'd3, 32'h00A00008);
        @(negedge clock);
        checkOutput("A_done", 32'(done), 32'd1);
        checkOutput("A_count", 32'(count), 32'd4);
        checkOutput("A_full", 32'(full), 32'd0);
        checkOutput("A_err_sticky", 32'(err), 32'd1);
        checkOutput("A_ready", 32'(in_ready), 32'd0);

        $display("[TB] program B: lw then j with in_last");
        start_load(6'd0);
        checkOutput("B_err_cleared", 32'(err), 32'd0);
        checkOutput("B_done_cleared", 32'(done), 32'd0);
        applyStimulus(5'd21, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0, 6'd0, 32'h8FA80004);
        applyStimulus(5'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 6'd1, 32'h08000010);
        @(negedge clock);
        checkOutput("B_done", 32'(done), 32'd1);
        checkOutput("B_count", 32'(count), 32'd2);

        $display("[TB] program C: base 2 fills memory without in_last");
        start_load(6'd2);
        applyStimulus(5'd13, 5'd4, 5'd5, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b0, 6'd2,
                      mdl_word(5'd13, 5'd4, 5'd5, 5'd0, 5'd0, 16'hFFFE, 26'h0));
        applyStimulus(5'd20, 5'd9, 5'd3, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0, 6'd3, 32'h3C031234);
        @(negedge clock);
        checkOutput("C_full", 32'(full), 32'd1);
        checkOutput("C_done", 32'(done), 32'd1);
        checkOutput("C_count", 32'(count), 32'd2);
        op_sel   = 5'd27;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("C_blocked_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        checkOutput("C_count_after", 32'(count), 32'd2);

        $display("[TB] program D: base at last word");
        start_load(6'd3);
        checkOutput("D_full_cleared", 32'(full), 32'd0);
        applyStimulus(5'd22, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b0, 6'd3, 32'h344300FF);
        @(negedge clock);
        checkOutput("D_full", 32'(full), 32'd1);
        checkOutput("D_done", 32'(done), 32'd1);
        checkOutput("D_count", 32'(count), 32'd1);

        $display("[TB] sweep: every op_sel with random fields");
        start_load(6'd0);
        slot = 0;
        for (int op = 0; op < 32; op++) begin
            r_s  = 5'($urandom);
            r_t  = 5'($urandom);
            r_d  = 5'($urandom);
            r_sh = 5'($urandom);
            r_im = 16'($urandom);
            r_tg = 26'($urandom);
            applyStimulus(5'(op), r_s, r_t, r_d, r_sh, r_im, r_tg, 1'b0, 6'(slot),
                          mdl_word(5'(op), r_s, r_t, r_d, r_sh, r_im, r_tg));
            if (op < 30) slot++;
            if (slot == DEPTH) begin
                @(negedge clock);
                checkOutput("sweep_full", 32'(full), 32'd1);
                checkOutput("sweep_count", 32'(count), 32'(DEPTH));
                start_load(6'd0);
                slot = 0;
            end
        end

        $display("[TB] reset asserted during WRITE");
        applyStimulus(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 6'(slot),
                      mdl_word(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0));
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("midreset");
        repeat (2) @(negedge clock);
        checkOutput("midreset_stays_idle", 32'(in_ready), 32'd0);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
